// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - master ids, default widths and command/read-tag types for ram_arb_2m
package ram_arb_pkg;

  localparam logic M0     = 1'b0;
  localparam logic M1     = 1'b1;
  localparam int   AW_DEF = 5;
  localparam int   DW_DEF = 8;

  typedef struct packed {
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic vld;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way arbiter with last-grant pointer; RAM_ARB_FIXED_PRIO_EN selects fixed m0 priority
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst_n, adv};

  assign gnt[0] = req[0];
  assign gnt[1] = req[1] & ~req[0];
`else
  logic last_q;

  // On a tie the requester that was not granted last time wins.
  assign gnt[0] = req[0] & (~req[1] | (last_q == M1));
  assign gnt[1] = req[1] & (~req[0] | (last_q == M0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= M1;
    end else if (adv) begin
      last_q <= gnt[1] ? M1 : M0;
    end
  end
`endif

endmodule

// File: rtl/ram_arb_2m.sv
// rtl/ram_arb_2m.sv - shares one synchronous single-port RAM between two requesters (RAM_ARB_FIXED_PRIO_EN: fixed priority)
module ram_arb_2m
  import ram_arb_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rd_data,
  output logic          m0_rd_vld,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rd_data,
  output logic          m1_rd_vld,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wr_data,
  input  logic [DW-1:0] ram_rd_data
);

  logic [1:0]    gnt;
  logic          any_gnt;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  rd_tag_t       tag_q [RD_LAT+1];
  rd_tag_t       tail;

  assign any_gnt = |gnt;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({m1_req, m0_req}),
    .adv   (any_gnt),
    .gnt   (gnt)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  always_comb begin
    sel_we    = m0_we;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (gnt[1]) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  // Address and write data hold across idle cycles; only en/we drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
    end else begin
      ram_en <= any_gnt;
      ram_we <= any_gnt & sel_we;
      if (any_gnt) begin
        ram_addr    <= sel_addr;
        ram_wr_data <= sel_wdata;
      end
    end
  end

  // Stage 0 lines up with the RAM command; the tail lines up with returned data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{vld: any_gnt & ~sel_we, id: gnt[1]};
      for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tail      = tag_q[RD_LAT];
  assign m0_rd_vld = tail.vld & (tail.id == M0);
  assign m1_rd_vld = tail.vld & (tail.id == M1);

  assign m0_rd_data = ram_rd_data;
  assign m1_rd_data = ram_rd_data;

endmodule

// File: tb/tb_ram_arb_2m.sv
// tb/tb_ram_arb_2m.sv - scoreboard bench for ram_arb_2m (expectations follow RAM_ARB_FIXED_PRIO_EN)
module tb_ram_arb_2m;
  import ram_arb_pkg::*;

  localparam int AW     = 5;
  localparam int DW     = 8;
  localparam int RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_gnt, m0_rd_vld;
  logic [DW-1:0] m0_rd_data;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_gnt, m1_rd_vld;
  logic [DW-1:0] m1_rd_data;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;

  always #5 clk = ~clk;

  ram_arb_2m #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_req      (m0_req),
    .m0_we       (m0_we),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_gnt      (m0_gnt),
    .m0_rd_data  (m0_rd_data),
    .m0_rd_vld   (m0_rd_vld),
    .m1_req      (m1_req),
    .m1_we       (m1_we),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_gnt      (m1_gnt),
    .m1_rd_data  (m1_rd_data),
    .m1_rd_vld   (m1_rd_vld),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_data (ram_rd_data)
  );

  // Block RAM model, read-first, RD_LAT clocks of read latency.
  logic [DW-1:0] mem [32];
  logic [DW-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wr_data;
      rd_pipe[0] <= mem[ram_addr];
    end
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rd_data = rd_pipe[RD_LAT-1];

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  rd_exp_t       exp_q [$];
  cmd_t          cq0 [$];
  cmd_t          cq1 [$];
  int            gnt_log [$];
  int            gnt_cyc [$];
  logic [DW-1:0] sh_mem [32];
  logic          exp_en = 1'b0, exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  int            rel_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic          e0, e1;
    logic [DW-1:0] ed;
    cmd_t          c;
    int            id;
    e0 = 1'b0;
    e1 = 1'b0;
    ed = '0;
    chk("ram_en", 32'(ram_en), 32'(exp_en));
    chk("ram_we", 32'(ram_we), 32'(exp_we));
    chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
    chk("ram_wr_data", 32'(ram_wr_data), 32'(exp_wdata));
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      ed = exp_q[0].data;
      if (exp_q[0].id == 0) e0 = 1'b1;
      else e1 = 1'b1;
      void'(exp_q.pop_front());
    end
    chk("m0_rd_vld", 32'(m0_rd_vld), 32'(e0));
    chk("m1_rd_vld", 32'(m1_rd_vld), 32'(e1));
    if (e0) chk("m0_rd_data", 32'(m0_rd_data), 32'(ed));
    if (e1) chk("m1_rd_data", 32'(m1_rd_data), 32'(ed));
    chk("gnt_legal", 32'((m0_gnt & m1_gnt) | (m0_gnt & ~m0_req) | (m1_gnt & ~m1_req)), 32'd0);
    chk("gnt_missing", 32'((m0_req | m1_req) & ~(m0_gnt | m1_gnt)), 32'd0);
    exp_en = 1'b0;
    exp_we = 1'b0;
    if (m0_gnt ^ m1_gnt) begin
      id = m1_gnt ? 1 : 0;
      if ((id == 1 && cq1.size() > 0) || (id == 0 && cq0.size() > 0)) begin
        c = (id == 1) ? cq1.pop_front() : cq0.pop_front();
        exp_en    = 1'b1;
        exp_we    = c.we;
        exp_addr  = c.addr;
        exp_wdata = c.wdata;
        gnt_log.push_back(id);
        gnt_cyc.push_back(cyc);
        if (c.we) sh_mem[c.addr] = c.wdata;
        else exp_q.push_back('{id, sh_mem[c.addr], cyc + 1 + RD_LAT});
      end
    end
  endtask

  // Requesters hold req with stable fields until the negedge sample sees gnt.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m0_req = rst_n && (cq0.size() > 0);
      m1_req = rst_n && (cq1.size() > 0);
      if (m0_req) begin
        m0_we = cq0[0].we; m0_addr = cq0[0].addr; m0_wdata = cq0[0].wdata;
      end
      if (m1_req) begin
        m1_we = cq1[0].we; m1_addr = cq1[0].addr; m1_wdata = cq1[0].wdata;
      end
      @(negedge clk);
      if (rst_n) monitor();
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((cq0.size() > 0 || cq1.size() > 0 || exp_q.size() > 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n >= 200), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  task automatic new_log();
    gnt_log.delete();
    gnt_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values while held, with a write already queued for m0.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_rd_vld", 32'({m0_rd_vld, m1_rd_vld}), 32'd0);
    new_log();
    cq0.push_back('{we: 1'b1, addr: 5'd3, wdata: 8'hA5});
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    rel_cyc = cyc;
    wait_idle();
    chk("t1_gnt_count", 32'(gnt_log.size()), 32'd1);
    if (gnt_log.size() == 1) begin
      chk("t1_gnt_id", 32'(gnt_log[0]), 32'd0);
      chk("t1_gnt_cycle", 32'(gnt_cyc[0] - rel_cyc), 32'd1);
    end
    chk("t1_ram_content", 32'(mem[3]), 32'hA5);

    // m0 reads back the written value.
    cq0.push_back('{we: 1'b0, addr: 5'd3, wdata: 8'h00});
    wait_idle();

    // m1 fills addrs 0..5, then both read 0..5 back-to-back.
    for (int i = 0; i < 6; i++) cq1.push_back('{we: 1'b1, addr: 5'(i), wdata: 8'(8'h11 * (i + 1))});
    wait_idle();
    new_log();
    for (int i = 0; i < 6; i++) begin
      cq0.push_back('{we: 1'b0, addr: 5'(i), wdata: 8'h00});
      cq1.push_back('{we: 1'b0, addr: 5'(5 - i), wdata: 8'h00});
    end
    wait_idle();
    chk("t3_gnt_count", 32'(gnt_log.size()), 32'd12);
    for (int i = 0; i < gnt_log.size(); i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      chk("t3_order", 32'(gnt_log[i]), 32'(i >= 6));
`else
      chk("t3_order", 32'(gnt_log[i]), 32'(i % 2));
`endif
      chk("t3_back_to_back", 32'(gnt_cyc[i] - gnt_cyc[0]), 32'(i));
    end

    // Four-deep tie: alternation, or m0 first then m1 in fixed priority.
    new_log();
    for (int i = 0; i < 4; i++) begin
      cq0.push_back('{we: 1'b0, addr: 5'(i), wdata: 8'h00});
      cq1.push_back('{we: 1'b0, addr: 5'(i + 2), wdata: 8'h00});
    end
    wait_idle();
    chk("t4_gnt_count", 32'(gnt_log.size()), 32'd8);
    for (int i = 0; i < gnt_log.size(); i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      chk("t4_order", 32'(gnt_log[i]), 32'(i >= 4));
`else
      chk("t4_order", 32'(gnt_log[i]), 32'(i % 2));
`endif
    end
    if (gnt_cyc.size() == 8) chk("t4_m1_after_drop", 32'(gnt_cyc[4] - gnt_cyc[3]), 32'd1);

    // m1 write then m0 read of the same address on the next cycle.
    new_log();
    cq1.push_back('{we: 1'b1, addr: 5'd7, wdata: 8'h3C});
    @(posedge clk);
    cq0.push_back('{we: 1'b0, addr: 5'd7, wdata: 8'h00});
    wait_idle();
    chk("t5_gnt_count", 32'(gnt_log.size()), 32'd2);
    if (gnt_log.size() == 2) begin
      chk("t5_first", 32'(gnt_log[0]), 32'd1);
      chk("t5_second", 32'(gnt_log[1]), 32'd0);
      chk("t5_gap", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd1);
    end

    // Two reads in flight, then reset.
    cq0.push_back('{we: 1'b0, addr: 5'd1, wdata: 8'h00});
    cq1.push_back('{we: 1'b0, addr: 5'd2, wdata: 8'h00});
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    cq0.delete();
    cq1.delete();
    exp_q.delete();
    exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    #1;
    chk("rst_mid_ram_en", 32'(ram_en), 32'd0);
    chk("rst_mid_ram_we", 32'(ram_we), 32'd0);
    chk("rst_mid_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_mid_ram_wr_data", 32'(ram_wr_data), 32'd0);
    chk("rst_mid_rd_vld", 32'({m0_rd_vld, m1_rd_vld}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    new_log();
    cq0.push_back('{we: 1'b0, addr: 5'd2, wdata: 8'h00});
    cq1.push_back('{we: 1'b0, addr: 5'd4, wdata: 8'h00});
    wait_idle();
    chk("t6_gnt_count", 32'(gnt_log.size()), 32'd2);
    if (gnt_log.size() == 2) chk("t6_first_tie", 32'(gnt_log[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
